// File: rtl/acc_mem_responder.sv
// acc_mem_responder: 64x16 memory with a two-stage pipelined read port,
// accepted-write counter and a background clear sequencer.
module acc_mem_responder (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [5:0]  Address,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   input  logic [15:0] WriteData,
   input  logic        ClearMem,
   output logic [15:0] ReadData,
   output logic        ReadValid,
   output logic        Busy,
   output logic        Conflict,
   output logic [6:0]  WriteCount
);
   typedef enum logic {IDLE, CLEARING} state_t;
   state_t state, state_nx;
   logic [15:0] mem [64];
   logic [5:0] clr_idx;
   logic [5:0] rd_addr;
   logic rd_pend;
   logic in_idle, wr_acc, rd_acc, conflict_nx, mem_we;
   logic [5:0] mem_addr;
   logic [15:0] mem_data;
   always_comb begin
      in_idle = state == IDLE;
      wr_acc = in_idle && WriteEnable;
      rd_acc = in_idle && ReadEnable && !WriteEnable;
      conflict_nx = in_idle ? (ReadEnable && WriteEnable) : (ReadEnable || WriteEnable);
      mem_we = !Reset && (wr_acc || !in_idle);
      mem_addr = in_idle ? Address : clr_idx;
      mem_data = in_idle ? WriteData : '0;
      state_nx = in_idle ? (ClearMem ? CLEARING : IDLE) : (clr_idx == 6'd63 ? IDLE : CLEARING);
   end
   always_ff @(posedge Clock)
      if (Reset) state <= IDLE;
      else state <= state_nx;
   // Storage has no reset so an aborted clear leaves untouched words intact.
   always_ff @(posedge Clock)
      if (mem_we) mem[mem_addr] <= mem_data;
   // The array is read a cycle after acceptance, so a write in that cycle stays invisible.
   always_ff @(posedge Clock)
      if (Reset) begin
         clr_idx <= '0;
         rd_pend <= 1'b0;
         rd_addr <= '0;
         ReadValid <= 1'b0;
         ReadData <= '0;
         Conflict <= 1'b0;
         WriteCount <= '0;
      end else begin
         clr_idx <= in_idle ? '0 : clr_idx + 6'd1;
         rd_pend <= rd_acc;
         rd_addr <= Address;
         ReadValid <= rd_pend;
         if (rd_pend) ReadData <= mem[rd_addr];
         Conflict <= conflict_nx;
         if (wr_acc && WriteCount != 7'd127) WriteCount <= WriteCount + 7'd1;
      end
   assign Busy = state == CLEARING;
endmodule
